// File: rtl/decoder_arbiter_4ch.sv
// Four-requester arbiter driving a shared 2-to-4 decoder (EN, A1, A0).
// Fixed-priority or round-robin selection, hold limit, and a one-cycle dead gap between owners.
module decoder_arbiter_4ch #(
  parameter int RR       = 1,
  parameter int HOLD_MAX = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] REQ,
  output logic       EN,
  output logic       A1,
  output logic       A0,
  output logic [3:0] GNT,
  output logic       BUSY,
  output logic       HOLD_EXP
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

  state_t     state_reg;
  logic [1:0] owner_reg;
  logic [1:0] last_reg;
  logic [7:0] cnt_reg;
  logic       hold_exp_reg;

  logic [3:0] req_rot;
  logic [1:0] rot_off;
  logic [1:0] rr_idx;
  logic [1:0] fp_idx;
  logic [1:0] win_idx;

  // Rotate requests so bit 0 is the requester just after the last owner.
  for (genvar gi = 0; gi < 4; gi++) begin : g_rot
    assign req_rot[gi] = REQ[last_reg + 2'(gi + 1)];
  end

  always_comb begin
    rot_off = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (req_rot[i]) rot_off = 2'(i);
    end
  end

  always_comb begin
    fp_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (REQ[i]) fp_idx = 2'(i);
    end
  end

  assign rr_idx  = last_reg + 2'd1 + rot_off;
  assign win_idx = (RR != 0) ? rr_idx : fp_idx;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg    <= IDLE;
      owner_reg    <= 2'd0;
      last_reg     <= 2'd3;
      cnt_reg      <= 8'd0;
      hold_exp_reg <= 1'b0;
    end else begin
      hold_exp_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (|REQ) begin
            owner_reg <= win_idx;
            cnt_reg   <= 8'd0;
            state_reg <= GRANT;
          end
        end
        GRANT: begin
          // A voluntary release wins over a coincident timeout.
          if (!REQ[owner_reg]) begin
            state_reg <= IDLE;
            last_reg  <= owner_reg;
            cnt_reg   <= 8'd0;
          end else if (cnt_reg == HOLD_LAST) begin
            state_reg    <= IDLE;
            last_reg     <= owner_reg;
            cnt_reg      <= 8'd0;
            hold_exp_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign EN       = (state_reg == GRANT);
  assign BUSY     = EN;
  assign A1       = owner_reg[1];
  assign A0       = owner_reg[0];
  assign HOLD_EXP = hold_exp_reg;

  for (genvar gi = 0; gi < 4; gi++) begin : g_gnt
    assign GNT[gi] = EN && (owner_reg == 2'(gi));
  end

endmodule

// File: tb/tb_decoder_arbiter_4ch.sv
// Directed bench for decoder_arbiter_4ch: a round-robin and a fixed-priority instance
// share clock, reset and requests; each vector checks one of them.
module tb_decoder_arbiter_4ch;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;

  logic       en_rr, a1_rr, a0_rr, busy_rr, hexp_rr;
  logic [3:0] gnt_rr;
  logic       en_fp, a1_fp, a0_fp, busy_fp, hexp_fp;
  logic [3:0] gnt_fp;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  decoder_arbiter_4ch #(.RR(1), .HOLD_MAX(4)) u_rr (
    .CLK(clk), .RST(rst), .REQ(req),
    .EN(en_rr), .A1(a1_rr), .A0(a0_rr), .GNT(gnt_rr), .BUSY(busy_rr), .HOLD_EXP(hexp_rr)
  );

  decoder_arbiter_4ch #(.RR(0), .HOLD_MAX(4)) u_fp (
    .CLK(clk), .RST(rst), .REQ(req),
    .EN(en_fp), .A1(a1_fp), .A0(a0_fp), .GNT(gnt_fp), .BUSY(busy_fp), .HOLD_EXP(hexp_fp)
  );

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       fp;
    logic [3:0] gnt;
    logic [1:0] a;
    logic       hexp;
  } vec_t;

  vec_t vecs[22];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input logic r, input logic [3:0] q);
    rst = r;
    req = q;
    step();
  endtask

  task automatic cmp(input string nm, input string fld, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s.%s: got %b, required %b", nm, fld, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input logic fp, input logic [3:0] eg,
                         input logic [1:0] ea, input logic eh);
    logic [3:0] g;
    logic       e, b, h;
    logic [1:0] a;
    if (fp) begin
      g = gnt_fp; e = en_fp; b = busy_fp; h = hexp_fp; a = {a1_fp, a0_fp};
    end else begin
      g = gnt_rr; e = en_rr; b = busy_rr; h = hexp_rr; a = {a1_rr, a0_rr};
    end
    $display("[%0t] %s %s rst=%b req=%b gnt=%b a=%b en=%b hold_exp=%b",
             $time, nm, fp ? "fp" : "rr", rst, req, g, a, e, h);
    cmp(nm, "gnt", g, eg);
    cmp(nm, "en", {3'b0, e}, {3'b0, |eg});
    cmp(nm, "busy", {3'b0, b}, {3'b0, |eg});
    cmp(nm, "a", {2'b0, a}, {2'b0, ea});
    cmp(nm, "hold_exp", {3'b0, h}, {3'b0, eh});
  endtask

  initial begin
    rst = 1'b1;
    req = 4'b1111;

    // Reset, round-robin order, reset mid-grant (rr instance)
    vecs[0]  = '{1'b1, 4'b1111, 1'b0, 4'b0000, 2'b00, 1'b0};
    vecs[1]  = '{1'b1, 4'b1111, 1'b0, 4'b0000, 2'b00, 1'b0};
    vecs[2]  = '{1'b0, 4'b1111, 1'b0, 4'b0001, 2'b00, 1'b0};
    vecs[3]  = '{1'b0, 4'b1110, 1'b0, 4'b0000, 2'b00, 1'b0};
    vecs[4]  = '{1'b0, 4'b1111, 1'b0, 4'b0010, 2'b01, 1'b0};
    vecs[5]  = '{1'b0, 4'b1101, 1'b0, 4'b0000, 2'b01, 1'b0};
    vecs[6]  = '{1'b0, 4'b1111, 1'b0, 4'b0100, 2'b10, 1'b0};
    vecs[7]  = '{1'b0, 4'b1011, 1'b0, 4'b0000, 2'b10, 1'b0};
    vecs[8]  = '{1'b0, 4'b1111, 1'b0, 4'b1000, 2'b11, 1'b0};
    vecs[9]  = '{1'b0, 4'b0111, 1'b0, 4'b0000, 2'b11, 1'b0};
    vecs[10] = '{1'b0, 4'b1111, 1'b0, 4'b0001, 2'b00, 1'b0};
    vecs[11] = '{1'b0, 4'b1110, 1'b0, 4'b0000, 2'b00, 1'b0};
    vecs[12] = '{1'b0, 4'b1111, 1'b0, 4'b0010, 2'b01, 1'b0};
    vecs[13] = '{1'b0, 4'b1111, 1'b0, 4'b0010, 2'b01, 1'b0};
    vecs[14] = '{1'b1, 4'b1111, 1'b0, 4'b0000, 2'b00, 1'b0};
    vecs[15] = '{1'b0, 4'b1111, 1'b0, 4'b0001, 2'b00, 1'b0};
    // Fixed priority (fp instance)
    vecs[16] = '{1'b1, 4'b0000, 1'b1, 4'b0000, 2'b00, 1'b0};
    vecs[17] = '{1'b0, 4'b0110, 1'b1, 4'b0100, 2'b10, 1'b0};
    vecs[18] = '{1'b0, 4'b0010, 1'b1, 4'b0000, 2'b10, 1'b0};
    vecs[19] = '{1'b0, 4'b0010, 1'b1, 4'b0010, 2'b01, 1'b0};
    vecs[20] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 2'b01, 1'b0};
    vecs[21] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 2'b01, 1'b0};

    for (int i = 0; i < 22; i++) begin
      apply(vecs[i].rst, vecs[i].req);
      chk_out($sformatf("vec%0d", i), vecs[i].fp, vecs[i].gnt, vecs[i].a, vecs[i].hexp);
    end

    // Timeout with a single steady requester (rr)
    apply(1'b1, 4'b0001);
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, 4'b0001);
      chk_out($sformatf("to_hold%0d", i), 1'b0, 4'b0001, 2'b00, 1'b0);
    end
    apply(1'b0, 4'b0001);
    chk_out("to_gap", 1'b0, 4'b0000, 2'b00, 1'b1);
    apply(1'b0, 4'b0001);
    chk_out("to_regrant", 1'b0, 4'b0001, 2'b00, 1'b0);

    // Timeout in round-robin: old owner drops to lowest priority
    apply(1'b1, 4'b0011);
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, 4'b0011);
      chk_out($sformatf("rrto_hold%0d", i), 1'b0, 4'b0001, 2'b00, 1'b0);
    end
    apply(1'b0, 4'b0011);
    chk_out("rrto_gap", 1'b0, 4'b0000, 2'b00, 1'b1);
    apply(1'b0, 4'b0011);
    chk_out("rrto_next", 1'b0, 4'b0010, 2'b01, 1'b0);

    // Timeout in fixed priority: highest requester wins again
    apply(1'b1, 4'b1001);
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, 4'b1001);
      chk_out($sformatf("fpto_hold%0d", i), 1'b1, 4'b1000, 2'b11, 1'b0);
    end
    apply(1'b0, 4'b1001);
    chk_out("fpto_gap", 1'b1, 4'b0000, 2'b11, 1'b1);
    apply(1'b0, 4'b1001);
    chk_out("fpto_again", 1'b1, 4'b1000, 2'b11, 1'b0);

    // Owner drops on the same edge the hold limit is reached
    apply(1'b1, 4'b0100);
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, 4'b0100);
      chk_out($sformatf("sim_hold%0d", i), 1'b1, 4'b0100, 2'b10, 1'b0);
    end
    apply(1'b0, 4'b0000);
    chk_out("sim_release", 1'b1, 4'b0000, 2'b10, 1'b0);
    apply(1'b0, 4'b0000);
    chk_out("sim_idle", 1'b1, 4'b0000, 2'b10, 1'b0);
    apply(1'b0, 4'b0100);
    chk_out("sim_regrant", 1'b1, 4'b0100, 2'b10, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
